kbd_autotype: RTL and testbench

- Keystroke-injection scheduler for the 8x8 active-low keyboard matrix that the AY-3-8910 port scans.
- Host logic (OSD paste, boot auto-run) pushes matrix key codes into an internal FIFO.
- The block replays each code as a timed press/hold/release sequence, with SHIFT applied when requested.
- It arbitrates with the live PS/2-driven matrix: injection only starts a key while the user holds no key, and the output is the AND of the live and injected matrices.

---
 rtl/kbd_autotype.sv | 173 +++++++++++++++++
 tb/tb_kbd_autotype.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_autotype.sv
// Keystroke-injection scheduler for the 8x8 active-low keyboard matrix.
// Queued key codes are replayed as SHIFT-setup / press / gap sequences.
module kbd_autotype #(
  parameter int FIFO_DEPTH   = 16,
  parameter int SETUP_CYCLES = 50000,
  parameter int HOLD_CYCLES  = 1000000,
  parameter int GAP_CYCLES   = 1000000,
  parameter int SHIFT_ROW    = 1,
  parameter int SHIFT_COL    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          abort,
  input  logic [63:0]                   live_matrix,
  output logic [63:0]                   matrix_out,
  output logic                          full,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_SH > GAP_CYCLES) ? MAX_SH : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [5:0]    SHIFT_IDX  = 6'(SHIFT_ROW * 8 + SHIFT_COL);
  localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PRESS = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // FIFO entries keep {shift, row, col}; the reserved bit is dropped on entry.
  logic [6:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [5:0]    code_r;
  logic [63:0]   inj_r;

  logic          live_idle_s;
  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          push_rej_s;
  logic [6:0]    head_s;
  logic          unused_s;

  // Handshake decode: push/pop qualification and FIFO status flags.
  always_comb begin
    live_idle_s = (live_matrix == {64{1'b1}});
    empty_s     = (count_r == CW'(0));
    full_s      = (count_r == CW'(FIFO_DEPTH));
    head_s      = fifo_mem_r[rd_ptr_r];
    pop_s       = (state_r == ST_IDLE) && !empty_s && live_idle_s && !abort;
    push_s      = wr_en && !full_s && !abort;
    push_rej_s  = wr_en && full_s && !abort;
    unused_s    = wr_data[6];
  end

  // Output merge: injected keys are ANDed onto the live matrix.
  always_comb begin
    matrix_out = live_matrix & inj_r;
    full       = full_s;
    busy       = (state_r != ST_IDLE) || !empty_s;
    count      = count_r;
    overflow   = overflow_r;
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {wr_data[7], wr_data[5:0]};
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      rd_ptr_r   <= AW'(0);
      wr_ptr_r   <= AW'(0);
      count_r    <= CW'(0);
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (push_rej_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Injection sequencer: SHIFT setup, key hold, release gap.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state_r <= ST_IDLE;
      timer_r <= TW'(0);
      code_r  <= 6'd0;
      inj_r   <= {64{1'b1}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            code_r <= head_s[5:0];
            if (head_s[6]) begin
              inj_r[SHIFT_IDX] <= 1'b0;
              state_r          <= ST_SETUP;
              timer_r          <= SETUP_LOAD;
            end else begin
              inj_r[head_s[5:0]] <= 1'b0;
              state_r            <= ST_PRESS;
              timer_r            <= HOLD_LOAD;
            end
          end
        end
        ST_SETUP: begin
          if (timer_r != TW'(0)) begin
            timer_r <= timer_r - TW'(1);
          end else begin
            inj_r[code_r] <= 1'b0;
            state_r       <= ST_PRESS;
            timer_r       <= HOLD_LOAD;
          end
        end
        ST_PRESS: begin
          if (timer_r != TW'(0)) begin
            timer_r <= timer_r - TW'(1);
          end else begin
            inj_r   <= {64{1'b1}};
            state_r <= ST_GAP;
            timer_r <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (timer_r != TW'(0)) begin
            timer_r <= timer_r - TW'(1);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          timer_r <= TW'(0);
          inj_r   <= {64{1'b1}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_autotype.sv
// Self-checking bench for kbd_autotype: directed table, corner sequences,
// and randomized traffic against a timeline-based reference model.
module tb_kbd_autotype;

  localparam int DEPTH     = 4;
  localparam int S         = 2;
  localparam int H         = 4;
  localparam int G         = 3;
  localparam int SHIFT_BIT = 11;
  localparam logic [63:0] ONES = {64{1'b1}};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        abort = 1'b0;
  logic [63:0] live_matrix = ONES;
  logic [63:0] matrix_out;
  logic        full;
  logic        busy;
  logic [2:0]  count;
  logic        overflow;

  kbd_autotype #(
    .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(S), .HOLD_CYCLES(H), .GAP_CYCLES(G),
    .SHIFT_ROW(1), .SHIFT_COL(3)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .abort(abort),
    .live_matrix(live_matrix), .matrix_out(matrix_out), .full(full), .busy(busy),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a code queue plus the timeline of the code being replayed.
  logic [7:0] q[$];
  bit         m_active = 1'b0;
  int         m_t0 = 0;
  int         m_end = 0;
  int         ecyc = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 1'b0;

  function automatic logic [63:0] exp_inj();
    logic [63:0] r = ONES;
    int ks;
    if (m_active) begin
      ks = m_t0 + (m_cur[7] ? S : 0);
      if (m_cur[7] && ecyc >= m_t0 && ecyc <= m_t0 + S + H - 1) r[SHIFT_BIT] = 1'b0;
      if (ecyc >= ks && ecyc <= ks + H - 1) r[m_cur[5:0]] = 1'b0;
    end
    return r;
  endfunction

  task automatic model_edge(input bit rst, input bit we, input logic [7:0] wd,
                            input bit ab, input logic [63:0] lv);
    bit idle_prev;
    bit full_prev;
    ecyc++;
    if (rst || ab) begin
      q.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      idle_prev = !m_active || (ecyc - 1 >= m_end);
      full_prev = (q.size() == DEPTH);
      if (idle_prev && q.size() > 0 && lv == ONES) begin
        m_cur    = q.pop_front();
        m_t0     = ecyc;
        m_end    = ecyc + (m_cur[7] ? S : 0) + H + G;
        m_active = 1'b1;
      end
      if (we) begin
        if (full_prev) m_ovf = 1'b1;
        else q.push_back(wd);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_model();
    bit m_busy;
    m_busy = !((!m_active || ecyc >= m_end) && q.size() == 0);
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("matrix_out", matrix_out, live_matrix & exp_inj());
  endtask

  task automatic step(input bit rst, input bit we, input logic [7:0] wd,
                      input bit ab, input logic [63:0] lv);
    @(negedge clk);
    reset = rst; wr_en = we; wr_data = wd; abort = ab; live_matrix = lv;
    @(posedge clk);
    model_edge(rst, we, wd, ab, lv);
    #1;
    check_model();
  endtask

  task automatic idle_n(input int n, input logic [63:0] lv);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b0, lv);
  endtask

  typedef struct {
    bit          rst;
    bit          we;
    logic [7:0]  wd;
    int          cnt;
    bit          bsy;
    logic [63:0] mo;
  } vec_t;

  function automatic vec_t mk(bit rst, bit we, logic [7:0] wd, int cnt, bit bsy,
                              logic [63:0] mo);
    vec_t v;
    v.rst = rst; v.we = we; v.wd = wd; v.cnt = cnt; v.bsy = bsy; v.mo = mo;
    return v;
  endfunction

  initial begin
    vec_t        tbl[21];
    logic [63:0] m42;
    logic [63:0] m11;
    logic [63:0] m1115;
    logic [63:0] lv;
    logic [7:0]  codes[5];

    m42   = ONES & ~(64'd1 << 42);
    m11   = ONES & ~(64'd1 << 11);
    m1115 = m11 & ~(64'd1 << 15);

    // Unshifted 0x2A then shifted 0x8F, expectations written out per cycle.
    tbl[0]  = mk(1'b1, 1'b0, 8'h00, 0, 1'b0, ONES);
    tbl[1]  = mk(1'b0, 1'b1, 8'h2A, 1, 1'b1, ONES);
    tbl[2]  = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, m42);
    tbl[3]  = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, m42);
    tbl[4]  = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, m42);
    tbl[5]  = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, m42);
    tbl[6]  = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, ONES);
    tbl[7]  = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, ONES);
    tbl[8]  = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, ONES);
    tbl[9]  = mk(1'b0, 1'b0, 8'h00, 0, 1'b0, ONES);
    tbl[10] = mk(1'b0, 1'b1, 8'h8F, 1, 1'b1, ONES);
    tbl[11] = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, m11);
    tbl[12] = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, m11);
    tbl[13] = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, m1115);
    tbl[14] = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, m1115);
    tbl[15] = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, m1115);
    tbl[16] = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, m1115);
    tbl[17] = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, ONES);
    tbl[18] = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, ONES);
    tbl[19] = mk(1'b0, 1'b0, 8'h00, 0, 1'b1, ONES);
    tbl[20] = mk(1'b0, 1'b0, 8'h00, 0, 1'b0, ONES);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rst, tbl[i].we, tbl[i].wd, 1'b0, ONES);
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
      chk($sformatf("tbl%0d_full", i), 64'(full), 64'd0);
      chk($sformatf("tbl%0d_ovf", i), 64'(overflow), 64'd0);
      chk($sformatf("tbl%0d_mo", i), matrix_out, tbl[i].mo);
    end

    // Overflow while the user holds live bit 0, then in-order replay.
    lv = ONES & ~64'd1;
    codes[0] = 8'h2A; codes[1] = 8'h81; codes[2] = 8'h05; codes[3] = 8'h13; codes[4] = 8'h3F;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, codes[i], 1'b0, lv);
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_mo", matrix_out, lv);
    for (int k = 0; k < 200 && (busy || k == 0); k++) step(1'b0, 1'b0, 8'h00, 1'b0, ONES);
    chk("ovf_drain_busy", 64'(busy), 64'd0);

    // Arbitration: no pop while live bit 9 is held.
    lv = ONES & ~(64'd1 << 9);
    step(1'b0, 1'b1, 8'h2A, 1'b0, lv);
    idle_n(5, lv);
    chk("arb_hold_count", 64'(count), 64'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, ONES);
    chk("arb_pop_count", 64'(count), 64'd0);
    chk("arb_pop_mo", matrix_out, m42);
    idle_n(H + G + 1, ONES);

    // Abort during PRESS with two queued codes and a concurrent push.
    step(1'b0, 1'b1, 8'h2A, 1'b0, ONES);
    step(1'b0, 1'b0, 8'h00, 1'b0, ONES);
    step(1'b0, 1'b1, 8'h05, 1'b0, ONES);
    step(1'b0, 1'b1, 8'h13, 1'b0, ONES);
    chk("abort_pre_count", 64'(count), 64'd2);
    step(1'b0, 1'b1, 8'h3F, 1'b1, ONES);
    chk("abort_count", 64'(count), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ovf", 64'(overflow), 64'd0);
    chk("abort_mo", matrix_out, ONES);
    idle_n(3, ONES);
    chk("abort_push_dropped", 64'(count), 64'd0);

    // Reset during SETUP.
    step(1'b0, 1'b1, 8'h8F, 1'b0, ONES);
    step(1'b0, 1'b0, 8'h00, 1'b0, ONES);
    chk("setup_mo", matrix_out, m11);
    lv = ONES & ~(64'd1 << 20);
    step(1'b1, 1'b0, 8'h00, 1'b0, lv);
    chk("rst_mo", matrix_out, lv);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit         r_rst;
      bit         r_ab;
      bit         r_we;
      logic [7:0] r_wd;
      r_rst = ($urandom % 256) == 0;
      r_ab  = ($urandom % 64) == 0;
      r_we  = ($urandom % 16) < ((i < 1500) ? 5 : 1);
      r_wd  = 8'($urandom);
      lv    = ONES;
      if (($urandom % 6) == 0) lv[$urandom % 64] = 1'b0;
      step(r_rst, r_we, r_wd, r_ab, lv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
